// File: rtl/status_poller.sv
// rtl/status_poller.sv - AXI4-Lite master polling busy/QSFP status registers
//
// Periodically reads register 0 (busy) and register 1 (QSFP) of a status
// slave and publishes the latest pair where both reads returned OKAY.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   enable               polling permitted
//   err_clear            pulse clearing rd_error / timeout_err
//   busy_status[1:0]     last good RDATA[1:0] of register 0
//   qsfp_status[1:0]     last good RDATA[1:0] of register 1
//   status_valid         a fully OKAY poll has completed
//   status_update        pulse when busy/qsfp are reloaded
//   rd_error             sticky: some RRESP != OKAY
//   timeout_err          sticky: some wait exceeded TIMEOUT_CYCLES
//   poll_count[15:0]     completed polls, wrapping
//   M_AXI_AR*/R*         read channels (one outstanding read)
//   M_AXI_AW*/W*/B*      write channels, tied off
module status_poller #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          POLL_CYCLES    = 250000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        err_clear,
    output logic [1:0]  busy_status,
    output logic [1:0]  qsfp_status,
    output logic        status_valid,
    output logic        status_update,
    output logic        rd_error,
    output logic        timeout_err,
    output logic [15:0] poll_count,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    output logic [2:0]  M_AXI_ARPROT,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    output logic [2:0]  M_AXI_AWPROT,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    output logic        M_AXI_BREADY
);

    localparam int TW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] TO_MAX     = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR0  = 3'd1;
    localparam logic [2:0] ST_R0   = 3'd2;
    localparam logic [2:0] ST_AR1  = 3'd3;
    localparam logic [2:0] ST_R1   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    tmp_busy_q, tmp_busy_d;
    logic          bad0_q, bad0_d;
    logic [1:0]    busy_q, busy_d;
    logic [1:0]    qsfp_q, qsfp_d;
    logic          valid_q, valid_d;
    logic          update_q, update_d;
    logic          rd_err_q, rd_err_d;
    logic          to_err_q, to_err_d;
    logic [15:0]   count_q, count_d;

    logic waiting;
    logic rd_set;
    logic to_set;
    logic unused_rdata;

    assign unused_rdata = ^M_AXI_RDATA[31:2];

    assign waiting = (state_q == ST_AR0) || (state_q == ST_R0) ||
                     (state_q == ST_AR1) || (state_q == ST_R1);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        to_cnt_d   = to_cnt_q;
        tmp_busy_d = tmp_busy_q;
        bad0_d     = bad0_q;
        busy_d     = busy_q;
        qsfp_d     = qsfp_q;
        valid_d    = valid_q;
        update_d   = 1'b0;
        count_d    = count_q;
        rd_set     = 1'b0;
        to_set     = 1'b0;

        if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && timer_q == '0) begin
                    state_d = ST_AR0;
                    timer_d = TIMER_LOAD;
                end
            end
            ST_AR0: if (M_AXI_ARREADY) state_d = ST_R0;
            ST_R0: begin
                if (M_AXI_RVALID) begin
                    state_d    = ST_AR1;
                    tmp_busy_d = M_AXI_RDATA[1:0];
                    bad0_d     = (M_AXI_RRESP != 2'b00);
                end
            end
            ST_AR1: if (M_AXI_ARREADY) state_d = ST_R1;
            ST_R1: begin
                // Results are committed on the R1 handshake so they are
                // visible during the single DONE cycle that follows.
                if (M_AXI_RVALID) begin
                    state_d = ST_DONE;
                    count_d = count_q + 16'd1;
                    if (!bad0_q && M_AXI_RRESP == 2'b00) begin
                        busy_d   = tmp_busy_q;
                        qsfp_d   = M_AXI_RDATA[1:0];
                        valid_d  = 1'b1;
                        update_d = 1'b1;
                    end else begin
                        rd_set = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Counter restarts on every state change; it saturates so the
        // sticky flag is set only once per stalled wait.
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if (waiting && to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
            to_set   = (to_cnt_q == TO_LAST);
        end

        // A new error in the same cycle as err_clear wins.
        rd_err_d = rd_set ? 1'b1 : (err_clear ? 1'b0 : rd_err_q);
        to_err_d = to_set ? 1'b1 : (err_clear ? 1'b0 : to_err_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            to_cnt_q   <= '0;
            tmp_busy_q <= 2'b00;
            bad0_q     <= 1'b0;
            busy_q     <= 2'b00;
            qsfp_q     <= 2'b00;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            to_err_q   <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            to_cnt_q   <= to_cnt_d;
            tmp_busy_q <= tmp_busy_d;
            bad0_q     <= bad0_d;
            busy_q     <= busy_d;
            qsfp_q     <= qsfp_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            rd_err_q   <= rd_err_d;
            to_err_q   <= to_err_d;
            count_q    <= count_d;
        end
    end

    // Channel controls decode straight from the state register, so an
    // asynchronous reset drops ARVALID/RREADY immediately.
    assign M_AXI_ARVALID = (state_q == ST_AR0) || (state_q == ST_AR1);
    assign M_AXI_RREADY  = (state_q == ST_R0) || (state_q == ST_R1);
    assign M_AXI_ARADDR  = (state_q == ST_AR0) ? BASE_ADDR :
                           (state_q == ST_AR1) ? (BASE_ADDR + 32'd4) : 32'd0;
    assign M_AXI_ARPROT  = 3'b000;

    assign M_AXI_AWADDR  = 32'd0;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_WDATA   = 32'd0;
    assign M_AXI_WSTRB   = 4'b0000;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = 1'b1;

    assign busy_status   = busy_q;
    assign qsfp_status   = qsfp_q;
    assign status_valid  = valid_q;
    assign status_update = update_q;
    assign rd_error      = rd_err_q;
    assign timeout_err   = to_err_q;
    assign poll_count    = count_q;

endmodule
